fem_sample_packer: RTL



---
 rtl/fem_sample_packer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/fem_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fem_sample_packer
//  Description : Packs quantised GNSS front-end I/Q samples into 32-bit words
//                (1, 2 or 4 bits per sample) and delivers them through a
//                small first-word-fall-through FIFO with valid/ready.
//                Supports a per-capture word limit and counts dropped words.
//  Revision    : 1.0  initial release
// ============================================================================
module fem_sample_packer #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] word_limit,
   input  logic             smp_valid,
   input  logic [1:0]       smp_i,
   input  logic [1:0]       smp_q,
   output logic [31:0]      word_data,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [15:0]      drop_count
);

   localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_FCNT_W = c_PTR_W + 1;
   localparam logic [c_FCNT_W-1:0] c_FULL  = c_FCNT_W'(FIFO_DEPTH);
   localparam logic [c_PTR_W-1:0]  c_P_ONE = c_PTR_W'(1);
   localparam logic [CNT_W-1:0]    c_W_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Control state
   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic [1:0]         r_mode;
   logic [CNT_W-1:0]   r_limit;
   logic [CNT_W-1:0]   r_word_cnt;
   logic               r_overflow;
   logic [15:0]        r_drop_cnt;

   // Packing datapath
   logic [4:0]         r_smp_cnt;
   logic [31:0]        r_acc;

   // FIFO storage
   logic [31:0]        r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_FCNT_W-1:0] r_fcnt;

   // Combinational helpers
   logic [31:0]        w_acc_next;
   logic [4:0]         w_last_idx;
   logic               w_smp_take;
   logic               w_word_done;
   logic               w_fifo_valid;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [CNT_W-1:0]   w_word_cnt_inc;

   // New samples enter at the top and shift down, so after a full word the
   // first sample of that word sits in the least significant field.
   always_comb begin
      w_acc_next = r_acc;
      w_last_idx = 5'd31;
      case (r_mode)
         2'd1: begin
            w_acc_next = {smp_i, r_acc[31:2]};
            w_last_idx = 5'd15;
         end
         2'd2: begin
            w_acc_next = {smp_q, smp_i, r_acc[31:4]};
            w_last_idx = 5'd7;
         end
         default: begin
            w_acc_next = {smp_i[1], r_acc[31:1]};
            w_last_idx = 5'd31;
         end
      endcase
   end

   assign w_smp_take     = (r_state == S_CAPTURE) && smp_valid;
   assign w_word_done    = w_smp_take && (r_smp_cnt == w_last_idx);
   assign w_empty        = (r_fcnt == '0);
   assign w_full         = (r_fcnt == c_FULL);
   assign w_fifo_valid   = !w_empty;
   assign w_pop          = w_fifo_valid && word_ready;
   // A simultaneous pop frees a slot, so a full FIFO can still accept.
   assign w_push         = w_word_done && (!w_full || w_pop);
   assign w_drop         = w_word_done && !w_push;
   assign w_word_cnt_inc = r_word_cnt + c_W_ONE;

   // Capture control FSM with registered busy/done and overflow accounting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mode     <= 2'd0;
         r_limit    <= '0;
         r_word_cnt <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode     <= (mode == 2'd3) ? 2'd0 : mode;
                  r_limit    <= word_limit;
                  r_word_cnt <= '0;
                  r_overflow <= 1'b0;
                  r_drop_cnt <= '0;
                  if (word_limit == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_CAPTURE;
                     r_busy  <= 1'b1;
                  end
               end
            end
            S_CAPTURE: begin
               if (w_word_done) begin
                  // Dropped words still count toward the limit.
                  r_word_cnt <= w_word_cnt_inc;
                  if (w_drop) begin
                     r_overflow <= 1'b1;
                     if (r_drop_cnt != 16'hFFFF) begin
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                     end
                  end
                  if (w_word_cnt_inc == r_limit) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (w_empty) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Sample position counter and shift accumulator; a new capture restarts
   // the word so no partial word survives across captures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_smp_cnt <= '0;
         r_acc     <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_smp_cnt <= '0;
         end else if (w_smp_take) begin
            r_acc     <= w_acc_next;
            r_smp_cnt <= w_word_done ? 5'd0 : (r_smp_cnt + 5'd1);
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fcnt   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_P_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_P_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + c_FCNT_W'(1);
            2'b01:   r_fcnt <= r_fcnt - c_FCNT_W'(1);
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

   // FIFO storage; contents only matter where the occupancy says so
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_acc_next;
      end
   end

   assign word_valid = w_fifo_valid;
   assign word_data  = w_fifo_valid ? r_mem[r_rd_ptr] : 32'h0;
   assign busy       = r_busy;
   assign done       = r_done;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_cnt;

endmodule
`default_nettype wire
